snow64_element_packer: RTL and testbench
========================================

SNOW64_ELEMENT_PACKER -- requirements
Module: snow64_element_packer

Interface
REQ-001 The block SHALL have no parameters; the line width is fixed at 256 bits (32 bytes).
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 start  in  1  one-cycle request to begin a packing job.
REQ-005 start_data_type  in  2  DataType encoding: 0 UnsgnInt, 1 SgnInt, 2 BFloat16, 3 Reserved.
REQ-006 start_int_type_size  in  2  IntTypeSize encoding: 0 Sz8, 1 Sz16, 2 Sz32, 3 Sz64; used only for integer types.
REQ-007 busy  out  1  high from job acceptance until the final line is accepted.
REQ-008 err_bad_type  out  1  one-cycle pulse when start is rejected.
REQ-009 in_valid  in  1, in_ready  out  1, in_data  in  64, in_last  in  1: scalar element input handshake.
REQ-010 out_valid  out  1, out_ready  in  1, out_data  out  256: packed line output handshake.
REQ-011 out_elem_count  out  6  number of lanes filled in out_data (1..32).
REQ-012 out_last  out  1  out_data holds the final line of the job.
REQ-013 out_overflow  out  1  at least one element in out_data lost significant bits on truncation.

Function
REQ-014 States SHALL be IDLE, FILL, OUT.
REQ-015 In IDLE, start with start_data_type != Reserved SHALL latch type and size and enter FILL next cycle; busy rises that same next cycle.
REQ-016 In IDLE, start with Reserved type SHALL pulse err_bad_type the next cycle and remain in IDLE.
REQ-017 start outside IDLE SHALL be ignored (no error pulse, no config change).
REQ-018 Element width w: UnsgnInt/SgnInt -> 8/16/32/64 per size; BFloat16 -> 16, size ignored.
REQ-019 Lanes per line L = 256/w (32, 16, 8, 4).
REQ-020 in_ready SHALL equal (state == FILL); in_ready is low in IDLE and OUT.
REQ-021 On in_valid && in_ready, in_data[w-1:0] SHALL be written to out_data[idx*w +: w]; idx increments by 1.
REQ-022 Overflow per element: UnsgnInt -> in_data[63:w] != 0; SgnInt -> in_data[63:w-1] not all equal; Sz64 and BFloat16 never overflow. The per-line flag is sticky (OR).
REQ-023 If the accepted element makes idx reach L, or in_last is 1, the block SHALL enter OUT next cycle with out_valid = 1.
REQ-024 out_elem_count = number of elements accepted into the line; unfilled lanes SHALL be zero.
REQ-025 out_last SHALL be 1 iff the line was closed by in_last (including in_last on the L-th element).
REQ-026 out_valid, out_data, out_elem_count, out_last and out_overflow SHALL hold stable while out_valid && !out_ready.
REQ-027 On out_valid && out_ready: the line buffer SHALL clear to zero, and idx and the overflow flag SHALL clear.
REQ-028 After that handshake, the block SHALL return to FILL if out_last = 0; otherwise it enters IDLE and busy falls.
REQ-029 Sustained throughput is L elements per L+1 cycles; one bubble per line is allowed.
REQ-030 A job SHALL have no maximum element count; only in_last ends it.

Reset
REQ-031 While rst is asserted, the block SHALL be in IDLE, with the buffer, idx, overflow flag and latched config zeroed.
REQ-032 While rst is asserted, busy, err_bad_type, in_ready, out_valid and out_last SHALL be 0, and out_data and out_elem_count SHALL be 0.
REQ-033 Reset mid-job SHALL discard any partial or pending line; no output handshake follows.

Verification
REQ-034 SgnInt/Sz8, inputs 0..31 with in_last on 31 -> one line: byte i = i, count 32, out_last 1, overflow 0; busy falls after accept.
REQ-035 UnsgnInt/Sz32, 10 elements 0x1..0xA with in_last on the 10th -> lines of count 8 then count 2; the second line's lanes 2..3 are zero and its out_last is 1.
REQ-036 SgnInt/Sz16, element 0xFFFF_FFFF_FFFF_8000 -> no overflow; element 0x0000_0000_0000_8000 -> overflow 1, lane = 0x8000.
REQ-037 BFloat16, in_last on the first element, out_ready held low 5 cycles -> outputs stable for 5 cycles; in_ready stays 0.
REQ-038 start with type 3 -> err_bad_type pulses once, busy stays 0; start while busy -> ignored.
REQ-039 rst asserted mid-FILL after 3 elements -> all outputs 0 immediately; the next job begins at lane 0.

Source files
------------

// File: rtl/snow64_element_packer_if.sv
// Handshake bundle for the element packer: job start, scalar element input
// stream and packed 256-bit line output stream.
interface snow64_element_packer_if;
    logic         start;
    logic [1:0]   start_data_type;
    logic [1:0]   start_int_type_size;
    logic         busy;
    logic         err_bad_type;

    logic         in_valid;
    logic         in_ready;
    logic [63:0]  in_data;
    logic         in_last;

    logic         out_valid;
    logic         out_ready;
    logic [255:0] out_data;
    logic [5:0]   out_elem_count;
    logic         out_last;
    logic         out_overflow;

    // Requester side: issues jobs, supplies elements, consumes lines.
    modport master (
        output start, start_data_type, start_int_type_size,
        input  busy, err_bad_type,
        output in_valid, in_data, in_last,
        input  in_ready,
        input  out_valid, out_data, out_elem_count, out_last, out_overflow,
        output out_ready
    );

    // Packer side.
    modport slave (
        input  start, start_data_type, start_int_type_size,
        output busy, err_bad_type,
        input  in_valid, in_data, in_last,
        output in_ready,
        output out_valid, out_data, out_elem_count, out_last, out_overflow,
        input  out_ready
    );
endinterface

// File: rtl/snow64_element_packer.sv
// Packs a stream of 64-bit scalar elements, truncated to the job's element
// width, into 256-bit lines. Tracks per-line truncation overflow and marks
// the line closed by in_last as the final one of the job.
module snow64_element_packer (
    input logic                   clk,
    input logic                   rst,
    snow64_element_packer_if.slave bus
);
    typedef enum logic [1:0] {
        Idle = 2'd0,
        Fill = 2'd1,
        Out  = 2'd2
    } state_t;

    localparam logic [1:0] TypeUnsgn = 2'd0;
    localparam logic [1:0] TypeSgn   = 2'd1;
    localparam logic [1:0] TypeBf16  = 2'd2;
    localparam logic [1:0] TypeRsvd  = 2'd3;

    state_t       state;
    logic [1:0]   dataType;
    logic [1:0]   intSize;
    logic [255:0] lineBuf;
    logic [5:0]   idx;
    logic         ovfFlag;
    logic         lastFlag;
    logic         errBadType;

    logic [1:0]   sizeSel;
    logic [5:0]   lanes;
    logic [5:0]   idxNext;
    logic [8:0]   bitOff;
    logic [63:0]  zext;
    logic [63:0]  sext;
    logic         elemOvf;
    logic         closeLine;
    logic [255:0] placed;

    // BFloat16 always packs as 16-bit lanes regardless of the latched size.
    assign sizeSel   = (dataType == TypeBf16) ? 2'd1 : intSize;
    assign lanes     = 6'd32 >> sizeSel;
    assign idxNext   = idx + 6'd1;
    assign closeLine = (idxNext == lanes) || bus.in_last;
    assign placed    = {192'b0, zext} << bitOff;

    // Truncate the incoming element and locate its lane within the line.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        zext   = bus.in_data;
        sext   = bus.in_data;
        bitOff = '0;
        unique case (sizeSel)
            2'd0: begin
                zext   = {56'b0, bus.in_data[7:0]};
                sext   = {{56{bus.in_data[7]}}, bus.in_data[7:0]};
                bitOff = {idx, 3'b000};
            end
            2'd1: begin
                zext   = {48'b0, bus.in_data[15:0]};
                sext   = {{48{bus.in_data[15]}}, bus.in_data[15:0]};
                bitOff = {idx[4:0], 4'b0000};
            end
            2'd2: begin
                zext   = {32'b0, bus.in_data[31:0]};
                sext   = {{32{bus.in_data[31]}}, bus.in_data[31:0]};
                bitOff = {idx[3:0], 5'b00000};
            end
            default: begin
                bitOff = {idx[2:0], 6'b000000};
            end
        endcase
    end

    // An element overflows when re-extending its kept bits does not give back
    // the full 64-bit input; BFloat16 is a bit-pattern copy and never does.
    always_comb begin
        elemOvf = 1'b0;
        if (dataType == TypeUnsgn)
            elemOvf = (zext != bus.in_data);
        else if (dataType == TypeSgn)
            elemOvf = (sext != bus.in_data);
    end

    // Job control, line accumulation and output holding.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the line buffer is reset too, so a stale partial line can
            // never leak into the next job and out_data reads zero in reset.
            state      <= Idle;
            dataType   <= '0;
            intSize    <= '0;
            lineBuf    <= '0;
            idx        <= '0;
            ovfFlag    <= 1'b0;
            lastFlag   <= 1'b0;
            errBadType <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register update
            // reading the pre-edge values, independent of statement order.
            errBadType <= 1'b0;
            unique case (state)
                Idle: begin
                    if (bus.start) begin
                        if (bus.start_data_type == TypeRsvd) begin
                            errBadType <= 1'b1;
                        end else begin
                            dataType <= bus.start_data_type;
                            intSize  <= bus.start_int_type_size;
                            state    <= Fill;
                        end
                    end
                end
                Fill: begin
                    if (bus.in_valid) begin
                        lineBuf <= lineBuf | placed;
                        idx     <= idxNext;
                        ovfFlag <= ovfFlag | elemOvf;
                        if (closeLine) begin
                            lastFlag <= bus.in_last;
                            state    <= Out;
                        end
                    end
                end
                Out: begin
                    if (bus.out_ready) begin
                        lineBuf  <= '0;
                        idx      <= '0;
                        ovfFlag  <= 1'b0;
                        lastFlag <= 1'b0;
                        state    <= lastFlag ? Idle : Fill;
                    end
                end
                default: state <= Idle;
            endcase
        end
    end

    assign bus.busy           = (state != Idle);
    assign bus.err_bad_type   = errBadType;
    assign bus.in_ready       = (state == Fill);
    assign bus.out_valid      = (state == Out);
    assign bus.out_data       = lineBuf;
    assign bus.out_elem_count = idx;
    assign bus.out_last       = lastFlag;
    assign bus.out_overflow   = ovfFlag;
endmodule

// File: tb/tb_snow64_element_packer.sv
// Self-checking bench for snow64_element_packer: an arithmetic line model fed
// by the element driver, a per-cycle output compare process, and literal
// expectations on the captured lines.
module tb_snow64_element_packer;
    logic clk;
    logic rst;

    snow64_element_packer_if bus ();

    snow64_element_packer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [255:0] data;
        int           count;
        bit           last;
        bit           ovf;
    } line_t;

    line_t expQ[$];
    line_t gotQ[$];

    int nChecks = 0;
    int nFails  = 0;

    // Model configuration and partial line.
    int           mW;
    bit           mSigned;
    bit           mFloat;
    logic [255:0] mLine;
    int           mCount;
    bit           mOvf;

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Model of one accepted element: truncate, place in next lane, judge range.
    task automatic modelAccept(input logic [63:0] data, input bit last);
        logic [63:0] lane;
        longint      v;
        longint      lim;
        bit          ovf;
        line_t       l;
        lane = (mW == 64) ? data : (data & ((64'd1 << mW) - 64'd1));
        ovf  = 1'b0;
        if (!mFloat && mW < 64) begin
            if (mSigned) begin
                v   = $signed(data);
                lim = longint'(1) <<< (mW - 1);
                ovf = (v >= lim) || (v < -lim);
            end else begin
                ovf = (data >> mW) != 64'd0;
            end
        end
        mLine  = mLine | (256'(lane) << (mCount * mW));
        mCount = mCount + 1;
        mOvf   = mOvf | ovf;
        if (mCount == 256 / mW || last) begin
            l.data  = mLine;
            l.count = mCount;
            l.last  = last;
            l.ovf   = mOvf;
            expQ.push_back(l);
            mLine  = '0;
            mCount = 0;
            mOvf   = 1'b0;
        end
    endtask

    // Compare every presented line against the model, including stall cycles.
    always @(negedge clk) begin
        if (!rst && bus.out_valid) begin
            check("in_ready_in_out", 256'(bus.in_ready), 256'(0));
            if (expQ.size() == 0) begin
                check("unexpected_line", 256'(bus.out_valid), 256'(0));
            end else begin
                check("line_data",  bus.out_data, expQ[0].data);
                check("line_count", 256'(bus.out_elem_count), 256'(expQ[0].count));
                check("line_last",  256'(bus.out_last), 256'(expQ[0].last));
                check("line_ovf",   256'(bus.out_overflow), 256'(expQ[0].ovf));
                if (bus.out_ready) begin
                    line_t g;
                    g.data  = bus.out_data;
                    g.count = int'(bus.out_elem_count);
                    g.last  = bus.out_last;
                    g.ovf   = bus.out_overflow;
                    gotQ.push_back(g);
                    void'(expQ.pop_front());
                end
            end
        end
    end

    // All driver tasks start and end at posedge+1.
    task automatic startJob(input logic [1:0] dt, input logic [1:0] sz);
        bus.start               = 1'b1;
        bus.start_data_type     = dt;
        bus.start_int_type_size = sz;
        @(posedge clk); #1;
        bus.start = 1'b0;
        mFloat  = (dt == 2'd2);
        mSigned = (dt == 2'd1);
        mW      = mFloat ? 16 : (8 << sz);
        mLine   = '0;
        mCount  = 0;
        mOvf    = 1'b0;
        gotQ.delete();
    endtask

    task automatic sendElem(input logic [63:0] data, input bit last);
        bit accepted;
        accepted     = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = data;
        bus.in_last  = last;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                @(posedge clk); #1;
                accepted = 1'b1;
                break;
            end
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        if (accepted) modelAccept(data, last);
        else check("in_accept_timeout", 256'(accepted), 256'(1));
    endtask

    task automatic waitIdle();
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!bus.busy) begin
                idle = 1'b1;
                break;
            end
        end
        check("job_end_idle", 256'(idle), 256'(1));
        check("job_lines_drained", 256'(expQ.size()), 256'(0));
        @(posedge clk); #1;
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, "_busy"},  256'(bus.busy), 256'(0));
        check({tag, "_err"},   256'(bus.err_bad_type), 256'(0));
        check({tag, "_inrdy"}, 256'(bus.in_ready), 256'(0));
        check({tag, "_ovld"},  256'(bus.out_valid), 256'(0));
        check({tag, "_olast"}, 256'(bus.out_last), 256'(0));
        check({tag, "_odata"}, bus.out_data, 256'(0));
        check({tag, "_ocnt"},  256'(bus.out_elem_count), 256'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst                     = 1'b1;
        bus.start               = 1'b0;
        bus.start_data_type     = '0;
        bus.start_int_type_size = '0;
        bus.in_valid            = 1'b0;
        bus.in_data             = '0;
        bus.in_last             = 1'b0;
        bus.out_ready           = 1'b1;
        mW = 8; mSigned = 1'b0; mFloat = 1'b0; mLine = '0; mCount = 0; mOvf = 1'b0;

        #1;
        checkAllZero("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // SgnInt/Sz8, 0..31, last on 31: one full line ending the job.
        startJob(2'd1, 2'd0);
        check("busy_after_start", 256'(bus.busy), 256'(1));
        for (int i = 0; i < 32; i++) sendElem(64'(i), i == 31);
        waitIdle();
        check("j1_nlines", 256'(gotQ.size()), 256'(1));
        if (gotQ.size() == 1) begin
            check("j1_data", gotQ[0].data,
                  256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100);
            check("j1_count", 256'(gotQ[0].count), 256'(32));
            check("j1_last",  256'(gotQ[0].last), 256'(1));
            check("j1_ovf",   256'(gotQ[0].ovf), 256'(0));
        end

        // UnsgnInt/Sz32, 1..10: a full line of 8 then a partial line of 2.
        startJob(2'd0, 2'd2);
        for (int i = 1; i <= 10; i++) sendElem(64'(i), i == 10);
        waitIdle();
        check("j2_nlines", 256'(gotQ.size()), 256'(2));
        if (gotQ.size() == 2) begin
            check("j2_l0_data", gotQ[0].data,
                  256'h0000000800000007000000060000000500000004000000030000000200000001);
            check("j2_l0_count", 256'(gotQ[0].count), 256'(8));
            check("j2_l0_last",  256'(gotQ[0].last), 256'(0));
            check("j2_l1_data",  gotQ[1].data, 256'h0000000a00000009);
            check("j2_l1_count", 256'(gotQ[1].count), 256'(2));
            check("j2_l1_last",  256'(gotQ[1].last), 256'(1));
        end

        // SgnInt/Sz16: -32768 fits, +32768 does not.
        startJob(2'd1, 2'd1);
        sendElem(64'hFFFF_FFFF_FFFF_8000, 1'b1);
        waitIdle();
        if (gotQ.size() == 1) check("j3_ovf", 256'(gotQ[0].ovf), 256'(0));
        else check("j3_nlines", 256'(gotQ.size()), 256'(1));
        startJob(2'd1, 2'd1);
        sendElem(64'h0000_0000_0000_8000, 1'b1);
        waitIdle();
        if (gotQ.size() == 1) begin
            check("j4_ovf",  256'(gotQ[0].ovf), 256'(1));
            check("j4_data", gotQ[0].data, 256'h8000);
        end else check("j4_nlines", 256'(gotQ.size()), 256'(1));

        // UnsgnInt/Sz16: 0x10000 overflows and truncates to zero.
        startJob(2'd0, 2'd1);
        sendElem(64'h1_0000, 1'b1);
        waitIdle();
        if (gotQ.size() == 1) begin
            check("j5_ovf",  256'(gotQ[0].ovf), 256'(1));
            check("j5_data", gotQ[0].data, 256'h0);
        end else check("j5_nlines", 256'(gotQ.size()), 256'(1));

        // UnsgnInt/Sz64: in_last on the 4th (L-th) element, no overflow.
        startJob(2'd0, 2'd3);
        sendElem(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        sendElem(64'd1, 1'b0);
        sendElem(64'd2, 1'b0);
        sendElem(64'd3, 1'b1);
        waitIdle();
        if (gotQ.size() == 1) begin
            check("j6_data", gotQ[0].data,
                  256'h000000000000000300000000000000020000000000000001ffffffffffffffff);
            check("j6_last", 256'(gotQ[0].last), 256'(1));
            check("j6_ovf",  256'(gotQ[0].ovf), 256'(0));
        end else check("j6_nlines", 256'(gotQ.size()), 256'(1));

        // BFloat16 with the consumer stalling: line held, no input accepted.
        startJob(2'd2, 2'd3);
        bus.out_ready = 1'b0;
        sendElem(64'h1234_ABCD, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", 256'(bus.out_valid), 256'(1));
            check("stall_inrdy", 256'(bus.in_ready), 256'(0));
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        waitIdle();
        if (gotQ.size() == 1) begin
            check("j7_data",  gotQ[0].data, 256'hABCD);
            check("j7_count", 256'(gotQ[0].count), 256'(1));
        end else check("j7_nlines", 256'(gotQ.size()), 256'(1));

        // Reserved type is rejected with a single error pulse.
        bus.start           = 1'b1;
        bus.start_data_type = 2'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("bad_type_err",  256'(bus.err_bad_type), 256'(1));
        check("bad_type_busy", 256'(bus.busy), 256'(0));
        @(posedge clk); #1;
        check("bad_type_err_once", 256'(bus.err_bad_type), 256'(0));
        check("bad_type_idle",     256'(bus.busy), 256'(0));

        // start while busy is ignored; the job keeps SgnInt/Sz8.
        startJob(2'd1, 2'd0);
        sendElem(64'h1FF, 1'b0);
        bus.start               = 1'b1;
        bus.start_data_type     = 2'd0;
        bus.start_int_type_size = 2'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("busy_start_err", 256'(bus.err_bad_type), 256'(0));
        sendElem(64'h05, 1'b0);
        sendElem(64'hFFFF_FFFF_FFFF_FF80, 1'b1);
        waitIdle();
        if (gotQ.size() == 1) begin
            check("j8_data",  gotQ[0].data, 256'h8005ff);
            check("j8_count", 256'(gotQ[0].count), 256'(3));
            check("j8_ovf",   256'(gotQ[0].ovf), 256'(1));
        end else check("j8_nlines", 256'(gotQ.size()), 256'(1));

        // Reset in the middle of filling discards the partial line.
        startJob(2'd0, 2'd0);
        sendElem(64'h11, 1'b0);
        sendElem(64'h22, 1'b0);
        sendElem(64'h33, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        checkAllZero("midrst");
        mLine = '0; mCount = 0; mOvf = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        startJob(2'd0, 2'd0);
        sendElem(64'h44, 1'b0);
        sendElem(64'h55, 1'b1);
        waitIdle();
        if (gotQ.size() == 1) begin
            check("j9_data",  gotQ[0].data, 256'h5544);
            check("j9_count", 256'(gotQ[0].count), 256'(2));
        end else check("j9_nlines", 256'(gotQ.size()), 256'(1));

        check("final_queue_empty", 256'(expQ.size()), 256'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
